// File: rtl/fpu_norm_pkg.sv
// Shared constants and helpers for the FPU post-add normalizer.
package fpu_norm_pkg;

  localparam int unsigned SIZE_MANTISSA = 23;
  localparam int unsigned SIZE_EXPONENT = 8;

  // All-ones biased exponent (infinity / NaN encoding)
  function automatic int unsigned exp_max(input int unsigned exp_width);
    return (32'd1 << exp_width) - 32'd1;
  endfunction

  localparam int unsigned EXP_MAX = exp_max(SIZE_EXPONENT);

  // Signed exponent intermediate, one bit wider than the biased exponent
  typedef logic signed [SIZE_EXPONENT:0] exp_ext_t;

endpackage

// File: rtl/fpu_lzc.sv
// Priority leading-zero counter; count equals WIDTH when the input is all zero.
module fpu_lzc #(
  parameter  int unsigned WIDTH = 24,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_bits,
  output logic [CW-1:0]    o_count,
  output logic             o_all_zero
);

  // Highest set bit wins because it is visited last
  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_bits[i]) o_count = CW'(WIDTH - 1 - i);
    end
  end

  assign o_all_zero = ~|i_bits;

endmodule

// File: rtl/fpu_normalizer.sv
// Single-cycle mantissa normalizer between the FPU adder and rounding.
// FPU_NORM_SUBNORMAL_EN selects gradual underflow instead of flush-to-zero.
module fpu_normalizer
  import fpu_norm_pkg::*;
#(
  parameter int unsigned Size_Mantissa = SIZE_MANTISSA,
  parameter int unsigned Size_Exponent = SIZE_EXPONENT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [Size_Mantissa+1:0] mantissa,
  input  logic [Size_Exponent-1:0] exponent,
  output logic                     out_valid,
  output logic [Size_Mantissa-1:0] normalized_mantissa,
  output logic [Size_Exponent-1:0] normalized_exponent,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned W  = Size_Mantissa;
  localparam int unsigned EW = Size_Exponent + 1;
  localparam int unsigned CW = $clog2(W + 2);
  localparam logic [EW-1:0] EMAX = EW'(exp_max(Size_Exponent));

  logic [CW-1:0]            w_lz;
  logic                     w_low_zero;
  logic [W:0]               w_shl;
  logic [EW-1:0]            w_exp_in;
  logic [EW-1:0]            w_exp_up;
  logic signed [EW-1:0]     w_exp_dn;
  logic [W-1:0]             w_frac;
  logic [Size_Exponent-1:0] w_exp;
  logic                     w_ovf;
  logic                     w_unf;

  logic                     r_valid;
  logic [W-1:0]             r_frac;
  logic [Size_Exponent-1:0] r_exp;
  logic                     r_ovf;
  logic                     r_unf;

  fpu_lzc #(.WIDTH(W + 1)) u_lzc (
    .i_bits     (mantissa[W:0]),
    .o_count    (w_lz),
    .o_all_zero (w_low_zero)
  );

  assign w_shl    = mantissa[W:0] << w_lz;
  assign w_exp_in = {1'b0, exponent};
  assign w_exp_up = w_exp_in + EW'(1);
  assign w_exp_dn = signed'(w_exp_in) - signed'(EW'(w_lz));

`ifdef FPU_NORM_SUBNORMAL_EN
  logic [Size_Exponent-1:0] w_sub_shift;
  logic [W:0]               w_sub;

  // Denormal shift stops where the exponent reaches its minimum
  assign w_sub_shift = (exponent == '0) ? '0 : exponent - Size_Exponent'(1);
  assign w_sub       = mantissa[W:0] << w_sub_shift;
`endif

  // Case select: carry right-shift, hidden-bit pass-through, or left normalize
  always_comb begin
    w_frac = '0;
    w_exp  = '0;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    if (mantissa[W+1]) begin
      if (w_exp_up >= EMAX) begin
        w_ovf = 1'b1;
        w_exp = Size_Exponent'(EMAX);
`ifdef FPU_NORM_SUBNORMAL_EN
      end else if (exponent == '0) begin
        w_unf  = 1'b1;
        w_frac = mantissa[W:1];
`endif
      end else begin
        w_frac = mantissa[W:1];
        w_exp  = Size_Exponent'(w_exp_up);
      end
    end else if (mantissa[W]) begin
      if (w_exp_in >= EMAX) begin
        w_ovf = 1'b1;
        w_exp = Size_Exponent'(EMAX);
      end else if (exponent == '0) begin
        w_unf = 1'b1;
`ifdef FPU_NORM_SUBNORMAL_EN
        w_frac = mantissa[W-1:0];
`endif
      end else begin
        w_frac = mantissa[W-1:0];
        w_exp  = exponent;
      end
    end else if (!w_low_zero) begin
      if (w_exp_dn[EW-1] || (w_exp_dn == '0)) begin
        w_unf = 1'b1;
`ifdef FPU_NORM_SUBNORMAL_EN
        w_frac = w_sub[W-1:0];
`endif
      end else begin
        w_frac = w_shl[W-1:0];
        w_exp  = Size_Exponent'(w_exp_dn);
      end
    end
  end

  // Output stage: data holds while idle, valid tracks the accepted input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_frac  <= '0;
      r_exp   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_frac <= w_frac;
        r_exp  <= w_exp;
        r_ovf  <= w_ovf;
        r_unf  <= w_unf;
      end
    end
  end

  assign out_valid           = r_valid;
  assign normalized_mantissa = r_frac;
  assign normalized_exponent = r_exp;
  assign overflow            = r_ovf;
  assign underflow           = r_unf;

endmodule

// File: tb/tb_fpu_normalizer.sv
// Directed self-checking bench for fpu_normalizer (default 23/8 widths).
module tb_fpu_normalizer;

  localparam int unsigned W = 23;
  localparam int unsigned E = 8;
  localparam int unsigned OW = 1 + W + E + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W+1:0] mantissa;
  logic [E-1:0] exponent;
  logic         out_valid;
  logic [W-1:0] normalized_mantissa;
  logic [E-1:0] normalized_exponent;
  logic         overflow;
  logic         underflow;

  logic [OW-1:0] got;
  logic [OW-1:0] want;
  int n_checks = 0;
  int n_fails  = 0;

  fpu_normalizer #(.Size_Mantissa(W), .Size_Exponent(E)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .mantissa            (mantissa),
    .exponent            (exponent),
    .out_valid           (out_valid),
    .normalized_mantissa (normalized_mantissa),
    .normalized_exponent (normalized_exponent),
    .overflow            (overflow),
    .underflow           (underflow)
  );

  always #5 clk = ~clk;

  assign got = {out_valid, normalized_mantissa, normalized_exponent, overflow, underflow};

  // Present one input, then sample 1 time unit after the capturing edge
  task automatic drive(input logic v, input logic [W+1:0] m, input logic [E-1:0] e);
    in_valid = v;
    mantissa = m;
    exponent = e;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 25'h1000003, 8'd100);
    want = '0;
    n_checks++;
    if (got !== want) begin
      $display("FAIL reset: got=%h exp=%h", got, want);
      n_fails++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    drive(1'b1, 25'h0800000, 8'd100);
    want = {1'b1, 23'h000000, 8'd100, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) begin
      $display("FAIL pass_through: got=%h exp=%h", got, want);
      n_fails++;
    end
    drive(1'b1, 25'h0ABCDEF, 8'd1);
    want = {1'b1, 23'h2BCDEF, 8'd1, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) begin
      $display("FAIL pass_through_e1: got=%h exp=%h", got, want);
      n_fails++;
    end
  endtask

  task automatic test_right_shift();
    drive(1'b1, 25'h1000003, 8'd100);
    want = {1'b1, 23'h000001, 8'd101, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) begin
      $display("FAIL right_shift: got=%h exp=%h", got, want);
      n_fails++;
    end
  endtask

  task automatic test_left_shift();
    drive(1'b1, 25'h0400000, 8'd100);
    want = {1'b1, 23'h000000, 8'd99, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) begin
      $display("FAIL left_shift_1: got=%h exp=%h", got, want);
      n_fails++;
    end
    drive(1'b1, 25'h0000001, 8'd100);
    want = {1'b1, 23'h000000, 8'd77, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) begin
      $display("FAIL left_shift_23: got=%h exp=%h", got, want);
      n_fails++;
    end
    drive(1'b1, 25'h0012345, 8'd100);
    want = {1'b1, 23'h11A280, 8'd93, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) begin
      $display("FAIL left_shift_7: got=%h exp=%h", got, want);
      n_fails++;
    end
  endtask

  task automatic test_underflow_zero();
    drive(1'b1, 25'h0000001, 8'd1);
`ifdef FPU_NORM_SUBNORMAL_EN
    want = {1'b1, 23'h000001, 8'd0, 1'b0, 1'b1};
`else
    want = {1'b1, 23'h000000, 8'd0, 1'b0, 1'b1};
`endif
    n_checks++;
    if (got !== want) begin
      $display("FAIL underflow_lshift: got=%h exp=%h", got, want);
      n_fails++;
    end
    drive(1'b1, 25'h0000000, 8'd50);
    want = {1'b1, 23'h000000, 8'd0, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) begin
      $display("FAIL exact_zero: got=%h exp=%h", got, want);
      n_fails++;
    end
    drive(1'b1, 25'h0812345, 8'd0);
`ifdef FPU_NORM_SUBNORMAL_EN
    want = {1'b1, 23'h012345, 8'd0, 1'b0, 1'b1};
`else
    want = {1'b1, 23'h000000, 8'd0, 1'b0, 1'b1};
`endif
    n_checks++;
    if (got !== want) begin
      $display("FAIL underflow_hidden_e0: got=%h exp=%h", got, want);
      n_fails++;
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, 25'h1000000, 8'd254);
    want = {1'b1, 23'h000000, 8'd255, 1'b1, 1'b0};
    n_checks++;
    if (got !== want) begin
      $display("FAIL overflow_carry: got=%h exp=%h", got, want);
      n_fails++;
    end
    drive(1'b1, 25'h1000000, 8'd253);
    want = {1'b1, 23'h000000, 8'd254, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) begin
      $display("FAIL no_overflow_253: got=%h exp=%h", got, want);
      n_fails++;
    end
    drive(1'b1, 25'h0800001, 8'd255);
    want = {1'b1, 23'h000000, 8'd255, 1'b1, 1'b0};
    n_checks++;
    if (got !== want) begin
      $display("FAIL overflow_hidden_255: got=%h exp=%h", got, want);
      n_fails++;
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 25'h0ABCDEF, 8'd42);
    drive(1'b0, 25'h1FFFFFF, 8'd7);
    want = {1'b0, 23'h2BCDEF, 8'd42, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) begin
      $display("FAIL hold_idle: got=%h exp=%h", got, want);
      n_fails++;
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 25'h0800000, 8'd10);
    want = {1'b1, 23'h000000, 8'd10, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) begin
      $display("FAIL b2b_first: got=%h exp=%h", got, want);
      n_fails++;
    end
    drive(1'b1, 25'h1000002, 8'd20);
    want = {1'b1, 23'h000001, 8'd21, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) begin
      $display("FAIL b2b_second: got=%h exp=%h", got, want);
      n_fails++;
    end
    rst_n = 1'b0;
    drive(1'b1, 25'h0400000, 8'd30);
    want = '0;
    n_checks++;
    if (got !== want) begin
      $display("FAIL b2b_reset: got=%h exp=%h", got, want);
      n_fails++;
    end
    rst_n = 1'b1;
    drive(1'b1, 25'h0400000, 8'd30);
    want = {1'b1, 23'h000000, 8'd29, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) begin
      $display("FAIL b2b_after_reset: got=%h exp=%h", got, want);
      n_fails++;
    end
    drive(1'b0, 25'h0000000, 8'd0);
    want = {1'b0, 23'h000000, 8'd29, 1'b0, 1'b0};
    n_checks++;
    if (got !== want) begin
      $display("FAIL b2b_drain: got=%h exp=%h", got, want);
      n_fails++;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    mantissa = '0;
    exponent = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_pass_through();
    test_right_shift();
    test_left_shift();
    test_underflow_zero();
    test_overflow();
    test_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fpu_normalizer.md
Name: fpu_normalizer

Overview:
- Post-arithmetic normalizer for the FPU datapath. It sits after the add/sub mantissa adder and before rounding/packing.
- Takes an unnormalized mantissa (carry bit + hidden bit + fraction) and its biased exponent.
- Produces a normalized fraction with the hidden bit dropped, an adjusted exponent, and overflow/underflow flags.
- Single-cycle registered stage with a valid qualifier.

Parameters:
- Size_Mantissa, 23, fraction width excluding the hidden bit.
- Size_Exponent, 8, biased exponent width. EXP_MAX = 2^Size_Exponent-1 (all ones).

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input qualifier.
- mantissa  in  Size_Mantissa+2  unnormalized mantissa. MSB is the carry bit; next bit is the hidden bit.
- exponent  in  Size_Exponent  biased exponent of the input.
- out_valid  out  1  output qualifier, asserted the cycle after an accepted input.
- normalized_mantissa  out  Size_Mantissa  normalized fraction, hidden bit removed.
- normalized_exponent  out  Size_Exponent  adjusted biased exponent.
- overflow  out  1  result exponent saturated to EXP_MAX.
- underflow  out  1  result exponent fell to 0 or below.

Behaviour:
- Reset: on a clk edge with rst_n=0, all outputs go to 0, including out_valid. Reset dominates in_valid.
- Latency is 1 cycle. A clk edge with in_valid=1 registers the result and sets out_valid=1.
- When in_valid=0, out_valid=0 and the data/flag outputs hold their last values.
- No backpressure. A new input can be accepted every cycle.
- Let W = Size_Mantissa, C = mantissa[W+1] (carry bit), H = mantissa[W] (hidden bit), e = exponent.
- Case C=1 (right shift by 1):
  - fraction = mantissa[W:1]; mantissa bit 0 is truncated.
  - new exponent = e+1, computed at Size_Exponent+1 bits.
- Case C=0, H=1 (pass-through): fraction = mantissa[W-1:0], exponent = e.
- Case C=0, H=0, mantissa nonzero (left shift):
  - lz = leading-zero count of mantissa[W:0], range 1..W.
  - Shift left by lz; fraction = bits [W-1:0] of the shifted value.
  - new exponent = e - lz, computed signed.
- Case mantissa == 0: output fraction 0, exponent 0, overflow=0, underflow=0. Exact zero is not an underflow.
- Overflow: new exponent >= EXP_MAX → overflow=1, exponent=EXP_MAX, fraction=0 (infinity).
- Underflow: new exponent <= 0 for nonzero input → underflow=1, exponent=0, fraction=0 (flush to zero).
  - Example: e=0 with H=1 underflows.
- overflow and underflow are never both 1.
- The leading-zero count and shifter are combinational; only the output stage is registered.

Optional Feature:
- Macro: FPU_NORM_SUBNORMAL_EN.
- Defined (gradual underflow):
  - When the left-shift case would make the exponent <= 0, shift by s = max(e-1, 0) instead of lz.
  - Output exponent = 0, fraction = bits [W-1:0] of mantissa shifted left by s, underflow=1.
  - The C=1 and H=1 cases with e=0 output a subnormal the same way: fraction from the unshifted/right-shifted value, exponent 0.
- Undefined: flush-to-zero as described in Behaviour.

Decomposition:
- Shared package fpu_norm_pkg holds:
  - default width constants;
  - the EXP_MAX computation;
  - a typedef for the signed Size_Exponent+1 exponent intermediate.
- One sub-module: fpu_lzc, a parameterized priority leading-zero counter over Size_Mantissa+1 bits.
  - Outputs the count plus an all-zero flag.

Test Plan:
1. mantissa=0x0800000, exponent=100, in_valid=1 → next cycle out_valid=1, normalized_mantissa=0x000000, normalized_exponent=100, overflow=0, underflow=0.
2. mantissa=0x1000003, exponent=100 → normalized_mantissa=0x000001 (bit 0 truncated), exponent=101, flags 0.
3. mantissa=0x0400000, exponent=100 → mantissa 0, exponent 99. Then mantissa=0x0000001, exponent=100 → mantissa 0, exponent 77.
4. mantissa=0x0000001, exponent=1 → underflow=1, exponent 0, mantissa 0. Then mantissa=0, exponent=50 → all outputs 0, underflow=0.
5. mantissa=0x1000000, exponent=254 → overflow=1, exponent=255, mantissa 0. Then exponent=253 → exponent 254, overflow=0.
6. Back-to-back inputs every cycle, with rst_n=0 asserted mid-stream → the next edge clears all outputs and out_valid. The first input after release appears 1 cycle later.
